// File: rtl/cv32e40s_clic_irq_arbiter.sv
// CLIC interrupt-source side: per-source pending/enable/level/shv/trigger
// state plus a registered max-level arbiter presenting one winner to the core.
// An acknowledge blanks the output for one extra cycle so that an id the
// core has just taken is never presented again from stale state.
module cv32e40s_clic_irq_arbiter #(
    parameter int NUM_INTERRUPTS = 32,
    parameter int CLIC_ID_WIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_INTERRUPTS-1:0] irq_src_i,
    input  logic                      cfg_we_i,
    input  logic [CLIC_ID_WIDTH-1:0]  cfg_id_i,
    input  logic                      cfg_ie_i,
    input  logic                      cfg_edge_i,
    input  logic                      cfg_shv_i,
    input  logic [7:0]                cfg_level_i,
    input  logic                      irq_ack_i,
    input  logic [CLIC_ID_WIDTH-1:0]  irq_ack_id_i,
    output logic                      clic_irq_o,
    output logic [CLIC_ID_WIDTH-1:0]  clic_irq_id_o,
    output logic [7:0]                clic_irq_level_o,
    output logic [1:0]                clic_irq_priv_o,
    output logic                      clic_irq_shv_o,
    output logic [NUM_INTERRUPTS-1:0] pending_o
);

    typedef enum logic {
        ARB,
        BLANK
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_INTERRUPTS-1:0] ip_q, ip_d;
    logic [NUM_INTERRUPTS-1:0] ie_q, edge_q, shv_q, src_q;
    logic [7:0]                level_q [NUM_INTERRUPTS];

    logic [31:0]               cfg_idx, ack_idx;
    logic                      cfg_valid, ack_valid;

    logic                      found;
    logic [CLIC_ID_WIDTH-1:0]  best_id;
    logic [7:0]                best_level;
    logic                      best_shv;

    logic                      irq_d;
    logic [CLIC_ID_WIDTH-1:0]  id_d;
    logic [7:0]                level_d;
    logic                      shv_d;

    // Out-of-range ids are widened and compared so they can never alias a real source
    assign cfg_idx   = 32'(cfg_id_i);
    assign ack_idx   = 32'(irq_ack_id_i);
    assign cfg_valid = cfg_we_i && (cfg_idx < 32'(NUM_INTERRUPTS));
    assign ack_valid = irq_ack_i && (ack_idx < 32'(NUM_INTERRUPTS));

    assign clic_irq_priv_o = 2'b11;
    assign pending_o       = ip_q;

    // Next pending state: level sources follow the line, edge sources latch rises
    always_comb begin
        ip_d = ip_q;
        for (int i = 0; i < NUM_INTERRUPTS; i++) begin
            if (edge_q[i] || (cfg_valid && cfg_idx == 32'(i) && cfg_edge_i)) begin
                if (irq_src_i[i] && !src_q[i]) begin
                    ip_d[i] = 1'b1;
                end else if ((cfg_valid && cfg_idx == 32'(i) && cfg_edge_i) ||
                             (ack_valid && ack_idx == 32'(i))) begin
                    ip_d[i] = 1'b0;
                end
            end else begin
                ip_d[i] = irq_src_i[i];
            end
        end
    end

    // Per-source pending, source history and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_q   <= '0;
            src_q  <= '0;
            ie_q   <= '0;
            edge_q <= '0;
            shv_q  <= '0;
            for (int i = 0; i < NUM_INTERRUPTS; i++) begin
                level_q[i] <= 8'h00;
            end
        end else begin
            ip_q  <= ip_d;
            src_q <= irq_src_i;
            for (int i = 0; i < NUM_INTERRUPTS; i++) begin
                if (cfg_valid && cfg_idx == 32'(i)) begin
                    ie_q[i]    <= cfg_ie_i;
                    edge_q[i]  <= cfg_edge_i;
                    shv_q[i]   <= cfg_shv_i;
                    level_q[i] <= cfg_level_i;
                end
            end
        end
    end

    // Highest level wins; scanning upward with >= hands ties to the highest id
    always_comb begin
        found      = 1'b0;
        best_id    = '0;
        best_level = 8'h00;
        best_shv   = 1'b0;
        for (int i = 0; i < NUM_INTERRUPTS; i++) begin
            if (ip_q[i] && ie_q[i] && (level_q[i] != 8'h00) && (level_q[i] >= best_level)) begin
                found      = 1'b1;
                best_id    = CLIC_ID_WIDTH'(i);
                best_level = level_q[i];
                best_shv   = shv_q[i];
            end
        end
    end

    // ARB/BLANK next state and next output-register values
    always_comb begin
        state_d = state_q;
        irq_d   = 1'b0;
        id_d    = clic_irq_id_o;
        level_d = clic_irq_level_o;
        shv_d   = clic_irq_shv_o;
        case (state_q)
            ARB: begin
                if (irq_ack_i) begin
                    state_d = BLANK;
                end else if (found) begin
                    irq_d   = 1'b1;
                    id_d    = best_id;
                    level_d = best_level;
                    shv_d   = best_shv;
                end
            end
            BLANK: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // FSM state and registered winner presented to the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ARB;
            clic_irq_o       <= 1'b0;
            clic_irq_id_o    <= '0;
            clic_irq_level_o <= 8'h00;
            clic_irq_shv_o   <= 1'b0;
        end else begin
            state_q          <= state_d;
            clic_irq_o       <= irq_d;
            clic_irq_id_o    <= id_d;
            clic_irq_level_o <= level_d;
            clic_irq_shv_o   <= shv_d;
        end
    end

endmodule
